// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipe_ctrl_pkg : shared encodings for the pipeline controller    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MDU_WAIT = 2'd1;
    localparam logic [1:0] HALT     = 2'd2;

    localparam logic [4:0] X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | hazard_detect : combinational load-use and redirect detection   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       sv_e_i,
    input  logic       sv_d_i,
    input  logic       mem_read_e_i,
    input  logic       reg_ren_d_i,
    input  logic [4:0] rd_e_i,
    input  logic [4:0] rs1_d_i,
    input  logic [4:0] rs2_d_i,
    input  logic       redirect_e_i,
    input  logic       adv_e_i,
    output logic       redir_o,
    output logic       load_use_o
);

    always_comb begin
        redir_o    = sv_e_i & redirect_e_i & adv_e_i;
        // A taken redirect squashes D anyway, so it masks the load-use stall.
        load_use_o = sv_e_i & sv_d_i & mem_read_e_i & reg_ren_d_i
                   & (rd_e_i != X0)
                   & ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i))
                   & ~redir_o;
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pipeline_ctrl : stage-advance controller for the 5-stage RV32   |
// | pipeline. MDU_STALL_EN enables the multi-cycle MUL/DIV stall.   |
// | Rev 1.1                                                         |
// +-----------------------------------------------------------------+
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       imem_ready,
    input  logic       dmem_req_M,
    input  logic       dmem_ack,
    input  logic       MemRead_E,
    input  logic [4:0] Rd_E,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic       reg_ren_D,
    input  logic       redirect_E,
    input  logic       mdu_op_E,
    input  logic       ebreak_W,
    output logic       pc_en,
    output logic       valid_F,
    output logic       ready_D,
    output logic       valid_D,
    output logic       ready_E,
    output logic       valid_E,
    output logic       ready_M,
    output logic       valid_M,
    output logic       ready_W,
    output logic       sv_D,
    output logic       sv_E,
    output logic       sv_M,
    output logic       sv_W,
    output logic       halted
);

    logic [1:0] r_state, w_state_nxt;
    logic       r_sv_d, r_sv_e, r_sv_m, r_sv_w;
    logic       w_sv_d_nxt, w_sv_e_nxt, w_sv_m_nxt, w_sv_w_nxt;
    logic       w_sv_d, w_sv_e, w_sv_m, w_sv_w;
    logic       w_halt, w_adv_m, w_adv_e, w_adv_d, w_mdu_busy;
    logic       w_redir, w_load_use;

    assign w_halt = (r_state == HALT) & ~rst;
    assign w_sv_d = r_sv_d & ~rst;
    assign w_sv_e = r_sv_e & ~rst;
    assign w_sv_m = r_sv_m & ~rst;
    assign w_sv_w = r_sv_w & ~rst;

    assign w_adv_m = ~(w_sv_m & dmem_req_M & ~dmem_ack);
    assign w_adv_e = w_adv_m & ~w_mdu_busy;
    assign w_adv_d = w_adv_e & ~w_load_use;

`ifdef MDU_STALL_EN
    localparam logic [7:0] C_MDU_LOAD = 8'(MDU_CYCLES - 1);

    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_counted, w_counted_nxt;
    logic       w_mdu_start;

    assign w_mdu_start = ~rst & (r_state == RUN) & w_sv_e & mdu_op_E & w_adv_m & ~r_counted;
    assign w_mdu_busy  = w_mdu_start | (~rst & (r_state == MDU_WAIT) & (r_cnt != 8'd1));

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_counted_nxt = r_counted;
        if (w_mdu_start) begin
            w_cnt_nxt     = C_MDU_LOAD;
            w_counted_nxt = 1'b1;
        end else begin
            if (r_state == MDU_WAIT) w_cnt_nxt = r_cnt - 8'd1;
            if (w_adv_e)             w_counted_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 8'd0;
            r_counted <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_counted <= w_counted_nxt;
        end
    end
`else
    logic w_unused_mdu;
    assign w_unused_mdu = mdu_op_E;
    assign w_mdu_busy   = 1'b0;
`endif

    hazard_detect u_hazard_detect (
        .sv_e_i       (w_sv_e),
        .sv_d_i       (w_sv_d),
        .mem_read_e_i (MemRead_E),
        .reg_ren_d_i  (reg_ren_D),
        .rd_e_i       (Rd_E),
        .rs1_d_i      (Rs1_D),
        .rs2_d_i      (Rs2_D),
        .redirect_e_i (redirect_E),
        .adv_e_i      (w_adv_e),
        .redir_o      (w_redir),
        .load_use_o   (w_load_use)
    );

    always_comb begin
        ready_W = ~w_halt;
        valid_M = w_adv_m & ~w_halt;
        ready_M = w_adv_m & ~w_halt;
        valid_E = w_adv_e & ~w_halt;
        ready_E = w_adv_e & ~w_halt;
        valid_D = ~w_load_use & ~w_halt;
        ready_D = w_adv_d & ~w_halt;
        valid_F = imem_ready & ~w_halt;
        pc_en   = ((w_adv_d & imem_ready) | w_redir) & ~w_halt;
        sv_D    = w_sv_d;
        sv_E    = w_sv_e;
        sv_M    = w_sv_m;
        sv_W    = w_sv_w;
        halted  = w_halt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sv_w_nxt  = r_sv_m & w_adv_m;
        w_sv_m_nxt  = w_adv_m ? (r_sv_e & w_adv_e) : r_sv_m;
        w_sv_e_nxt  = w_adv_e ? (r_sv_d & ~w_load_use & ~w_redir) : r_sv_e;
        w_sv_d_nxt  = w_redir ? 1'b0 : (w_adv_d ? imem_ready : r_sv_d);
        if ((r_state == HALT) || (r_sv_w && ebreak_W)) begin
            w_state_nxt = HALT;
            w_sv_w_nxt  = 1'b0;
            w_sv_m_nxt  = 1'b0;
            w_sv_e_nxt  = 1'b0;
            w_sv_d_nxt  = 1'b0;
        end
`ifdef MDU_STALL_EN
        else if (w_mdu_start) begin
            w_state_nxt = MDU_WAIT;
        end else if ((r_state == MDU_WAIT) && (r_cnt == 8'd1)) begin
            w_state_nxt = RUN;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_sv_d  <= 1'b0;
            r_sv_e  <= 1'b0;
            r_sv_m  <= 1'b0;
            r_sv_w  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sv_d  <= w_sv_d_nxt;
            r_sv_e  <= w_sv_e_nxt;
            r_sv_m  <= w_sv_m_nxt;
            r_sv_w  <= w_sv_w_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_pipeline_ctrl : directed self-checking bench for the         |
// | pipeline controller. Rev 1.1                                    |
// +-----------------------------------------------------------------+
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_ready, dmem_req_M, dmem_ack, MemRead_E, reg_ren_D;
    logic [4:0] Rd_E, Rs1_D, Rs2_D;
    logic       redirect_E, mdu_op_E, ebreak_W;
    logic       pc_en, valid_F, ready_D, valid_D, ready_E, valid_E;
    logic       ready_M, valid_M, ready_W;
    logic       sv_D, sv_E, sv_M, sv_W, halted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MDU_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ready (imem_ready),
        .dmem_req_M (dmem_req_M),
        .dmem_ack   (dmem_ack),
        .MemRead_E  (MemRead_E),
        .Rd_E       (Rd_E),
        .Rs1_D      (Rs1_D),
        .Rs2_D      (Rs2_D),
        .reg_ren_D  (reg_ren_D),
        .redirect_E (redirect_E),
        .mdu_op_E   (mdu_op_E),
        .ebreak_W   (ebreak_W),
        .pc_en      (pc_en),
        .valid_F    (valid_F),
        .ready_D    (ready_D),
        .valid_D    (valid_D),
        .ready_E    (ready_E),
        .valid_E    (valid_E),
        .ready_M    (ready_M),
        .valid_M    (valid_M),
        .ready_W    (ready_W),
        .sv_D       (sv_D),
        .sv_E       (sv_E),
        .sv_M       (sv_M),
        .sv_W       (sv_W),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; dmem_req_M = 1'b0; dmem_ack = 1'b1;
        MemRead_E = 1'b0; reg_ren_D = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
        redirect_E = 1'b0; mdu_op_E = 1'b0; ebreak_W = 1'b0;
        settle();
        chk("rst_pc_en", pc_en, 1'b1);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ready_D", ready_D, 1'b1);
        imem_ready = 1'b0; settle();
        chk("rst_pc_en_noimem", pc_en, 1'b0);
        imem_ready = 1'b1;
        tick();
        rst = 1'b0; settle();
        chk("rst_sv_D", sv_D, 1'b0);
        chk("rst_sv_W", sv_W, 1'b0);
        tick();
        chk("fill1_sv_D", sv_D, 1'b1);
        chk("fill1_sv_E", sv_E, 1'b0);
        tick(); tick(); tick();
        chk("fill4_sv_W", sv_W, 1'b1);

        MemRead_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd1; settle();
        chk("lu_ready_D", ready_D, 1'b0);
        chk("lu_valid_D", valid_D, 1'b0);
        chk("lu_pc_en", pc_en, 1'b0);
        chk("lu_ready_E", ready_E, 1'b1);
        tick();
        MemRead_E = 1'b0; settle();
        chk("lu_bubble_sv_E", sv_E, 1'b0);
        chk("lu_hold_sv_D", sv_D, 1'b1);
        chk("lu_after_ready_D", ready_D, 1'b1);
        tick();
        chk("lu_issue_sv_E", sv_E, 1'b1);

        MemRead_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0; settle();
        chk("x0_ready_D", ready_D, 1'b1);
        chk("x0_valid_D", valid_D, 1'b1);

        Rd_E = 5'd5; Rs1_D = 5'd5; redirect_E = 1'b1; imem_ready = 1'b0; settle();
        chk("redir_pc_en", pc_en, 1'b1);
        chk("redir_valid_D", valid_D, 1'b1);
        tick();
        redirect_E = 1'b0; MemRead_E = 1'b0; imem_ready = 1'b1; settle();
        chk("redir_sv_D", sv_D, 1'b0);
        chk("redir_sv_E", sv_E, 1'b0);
        chk("redir_sv_M", sv_M, 1'b1);
        tick(); tick(); tick();
        chk("refill_sv_M", sv_M, 1'b1);
        chk("refill_sv_W", sv_W, 1'b0);

        dmem_req_M = 1'b1; dmem_ack = 1'b0; imem_ready = 1'b0; redirect_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mw_ready_M", ready_M, 1'b0);
            chk("mw_ready_E", ready_E, 1'b0);
            chk("mw_pc_en", pc_en, 1'b0);
            tick();
            chk("mw_sv_W", sv_W, 1'b0);
            chk("mw_sv_M", sv_M, 1'b1);
        end
        dmem_ack = 1'b1; settle();
        chk("mw_ack_ready_M", ready_M, 1'b1);
        chk("mw_ack_pc_en", pc_en, 1'b1);
        tick();
        dmem_req_M = 1'b0; redirect_E = 1'b0; imem_ready = 1'b1; settle();
        chk("mw_retire_sv_W", sv_W, 1'b1);
        chk("mw_redir_sv_D", sv_D, 1'b0);
        chk("mw_redir_sv_E", sv_E, 1'b0);

`ifdef MDU_STALL_EN
        tick(); tick();
        chk("mdu_pre_sv_E", sv_E, 1'b1);
        mdu_op_E = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mdu_ready_E_low", ready_E, 1'b0);
            chk("mdu_ready_M", ready_M, 1'b1);
            tick();
        end
        settle();
        chk("mdu_release_ready_E", ready_E, 1'b1);
        tick();
        mdu_op_E = 1'b0; settle();
        chk("mdu_moved_sv_M", sv_M, 1'b1);
`endif

        tick(); tick(); tick(); tick();
        chk("halt_pre_sv_W", sv_W, 1'b1);
        ebreak_W = 1'b1; settle();
        chk("halt_same_cycle_halted", halted, 1'b0);
        chk("halt_same_cycle_ready_W", ready_W, 1'b1);
        tick();
        ebreak_W = 1'b0; settle();
        chk("halt_halted", halted, 1'b1);
        chk("halt_ready_W", ready_W, 1'b0);
        chk("halt_pc_en", pc_en, 1'b0);
        chk("halt_valid_F", valid_F, 1'b0);
        chk("halt_sv_D", sv_D, 1'b0);
        chk("halt_sv_W", sv_W, 1'b0);
        tick(); tick();
        chk("halt_sticky", halted, 1'b1);
        chk("halt_sticky_ready_M", ready_M, 1'b0);
        chk("halt_sticky_valid_D", valid_D, 1'b0);
        rst = 1'b1; settle();
        chk("halt_rst_pc_en", pc_en, 1'b1);
        tick();
        rst = 1'b0; settle();
        chk("post_rst_halted", halted, 1'b0);
        chk("post_rst_sv_D", sv_D, 1'b0);
        chk("post_rst_sv_W", sv_W, 1'b0);
        tick();
        chk("post_rst_fill_sv_D", sv_D, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
